// File: rtl/song_addr_sequencer.sv
// Record/playback address sequencer for a slotted song memory: steps one word every
// SAMPLES_PER_WORD sample strobes and keeps the recorded length of each slot.
module song_addr_sequencer #(
  parameter int unsigned ADDR_W           = 19,
  parameter int unsigned NUM_SLOTS        = 12,
  parameter int unsigned SLOT_W           = 4,
  parameter int unsigned SLOT_LEN         = 40000,
  parameter int unsigned BASE_ADDR        = 0,
  parameter int unsigned SAMPLES_PER_WORD = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              record,
  input  logic              loop,
  input  logic [SLOT_W-1:0] slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SLOT_W-1:0] cur_slot,
  output logic [ADDR_W-1:0] slot_len
);

  localparam int unsigned PHASE_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

  typedef enum logic [1:0] {StIdle, StRec, StPlay} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   len_q [NUM_SLOTS];
  logic [ADDR_W-1:0]   len_d [NUM_SLOTS];
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                slot_ok, adv, last_phase, wev;
  logic [ADDR_W-1:0]   cur_base, off_next, cur_len;

  function automatic logic [ADDR_W-1:0] base_of(input logic [SLOT_W-1:0] s);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(s) * ADDR_W'(SLOT_LEN);
  endfunction

  assign slot_ok    = int'(slot) < int'(NUM_SLOTS);
  assign busy       = (state_q != StIdle);
  assign adv        = busy & sample_en & ~pause & ~start & ~stop;
  assign last_phase = (phase_q == PHASE_W'(SAMPLES_PER_WORD - 1));
  assign wev        = adv & last_phase;
  assign cur_base   = base_of(slot_q);
  assign off_next   = addr_q - cur_base + ADDR_W'(1);
  assign cur_len    = len_q[slot_q];

  assign mem_we   = (state_q == StRec) & wev;
  assign mem_re   = (state_q == StPlay) & wev;
  assign mem_addr = addr_q;
  assign cur_slot = slot_q;
  assign slot_len = cur_len;
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (start) begin
      if (slot_ok) begin
        slot_d  = slot;
        addr_d  = base_of(slot);
        phase_d = '0;
        if (record) begin
          len_d[slot] = '0;
          state_d     = StRec;
        end else if (len_q[slot] != '0) begin
          state_d = StPlay;
        end else begin
          // Nothing recorded: finish immediately.
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (stop) begin
      if (busy) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else if (adv) begin
      phase_d = last_phase ? '0 : phase_q + PHASE_W'(1);
      if (last_phase) begin
        if (state_q == StRec) begin
          len_d[slot_q] = off_next;
          if (off_next == ADDR_W'(SLOT_LEN)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          if (off_next == cur_len) begin
            if (loop) begin
              addr_d = cur_base;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= ADDR_W'(BASE_ADDR);
      phase_q <= '0;
      slot_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_song_addr_sequencer.sv
// Directed bench for song_addr_sequencer: record, stop, play, loop, pause, bad slot and reset.
module tb_song_addr_sequencer;

  localparam int unsigned ADDR_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sample_en, start, stop, pause, record, loop;
  logic [1:0] slot;

  logic [ADDR_W-1:0] mem_addr, slot_len;
  logic mem_we, mem_re, busy, done, err;
  logic [1:0] cur_slot;

  logic [ADDR_W-1:0] b_mem_addr, b_slot_len;
  logic b_mem_we, b_mem_re, b_busy, b_done, b_err;
  logic [1:0] b_cur_slot;

  int n_vec = 0;
  int n_err = 0;

  song_addr_sequencer #(
    .ADDR_W(ADDR_W), .NUM_SLOTS(4), .SLOT_W(2), .SLOT_LEN(4), .BASE_ADDR(16),
    .SAMPLES_PER_WORD(3)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .start(start), .stop(stop),
    .pause(pause), .record(record), .loop(loop), .slot(slot), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done), .err(err),
    .cur_slot(cur_slot), .slot_len(slot_len)
  );

  // Three-slot copy sharing the inputs, so slot 3 is out of range for it.
  song_addr_sequencer #(
    .ADDR_W(ADDR_W), .NUM_SLOTS(3), .SLOT_W(2), .SLOT_LEN(4), .BASE_ADDR(16),
    .SAMPLES_PER_WORD(3)
  ) dut_b (
    .clk(clk), .reset(reset), .sample_en(sample_en), .start(start), .stop(stop),
    .pause(pause), .record(record), .loop(loop), .slot(slot), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .busy(b_busy), .done(b_done), .err(b_err),
    .cur_slot(b_cur_slot), .slot_len(b_slot_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] s, input logic rec);
    slot   = s;
    record = rec;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic samp(input string tag, input logic exp_we, input logic exp_re, input int exp_addr);
    sample_en = 1'b1;
    @(negedge clk);
    chk({tag, ".we"}, mem_we, exp_we);
    chk({tag, ".re"}, mem_re, exp_re);
    if (exp_we || exp_re) chk({tag, ".addr"}, mem_addr, exp_addr);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; record = 1'b0; loop = 1'b0; slot = 2'd0;
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.addr", mem_addr, 16);
    chk("rst.slot", cur_slot, 0);
    chk("rst.len", slot_len, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    reset = 1'b0;
    tick();

    // Full record of slot 1 (base 20)
    pulse_start(2'd1, 1'b1);
    chk("rec.busy", busy, 1);
    chk("rec.addr0", mem_addr, 20);
    chk("rec.slot", cur_slot, 1);
    for (int i = 1; i <= 12; i++) samp("rec_full", (i % 3) == 0, 1'b0, 20 + i / 3 - 1);
    chk("rec.done", done, 1);
    chk("rec.idle", busy, 0);
    chk("rec.len", slot_len, 4);
    chk("rec.hold", mem_addr, 23);
    tick();
    chk("rec.done_clr", done, 0);

    // Short record stopped after two words, then play back
    pulse_start(2'd1, 1'b1);
    chk("rec2.len_clr", slot_len, 0);
    for (int i = 1; i <= 6; i++) samp("rec2", (i % 3) == 0, 1'b0, 20 + i / 3 - 1);
    pulse_stop();
    chk("rec2.done", done, 1);
    chk("rec2.idle", busy, 0);
    chk("rec2.len", slot_len, 2);
    pulse_start(2'd1, 1'b0);
    chk("play.busy", busy, 1);
    chk("play.addr0", mem_addr, 20);
    for (int i = 1; i <= 6; i++) samp("play", 1'b0, (i % 3) == 0, 20 + i / 3 - 1);
    chk("play.done", done, 1);
    chk("play.idle", busy, 0);
    chk("play.hold", mem_addr, 21);

    // Looped playback
    loop = 1'b1;
    pulse_start(2'd1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      samp("loop", 1'b0, (i % 3) == 0, 20 + ((i / 3 - 1) % 2));
      chk("loop.nodone", done, 0);
    end
    chk("loop.busy", busy, 1);
    pulse_stop();
    chk("loop.done", done, 1);
    chk("loop.idle", busy, 0);
    loop = 1'b0;

    // Pause mid-record of slot 0 (base 16)
    pulse_start(2'd0, 1'b1);
    for (int i = 1; i <= 4; i++) samp("prec", i == 3, 1'b0, 16);
    chk("pause.addr_pre", mem_addr, 17);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) samp("paused", 1'b0, 1'b0, 0);
    chk("pause.addr", mem_addr, 17);
    chk("pause.busy", busy, 1);
    pause = 1'b0;
    samp("resume5", 1'b0, 1'b0, 0);
    samp("resume6", 1'b1, 1'b0, 17);
    pulse_stop();
    chk("pause.len", slot_len, 2);

    // Play of an empty slot finishes at once
    slot = 2'd2; record = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("empty.re", mem_re, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("empty.done", done, 1);
    chk("empty.busy", busy, 0);
    chk("empty.slot", cur_slot, 2);
    chk("empty.err", err, 0);
    tick();
    chk("empty.done_clr", done, 0);

    // Slot 3: valid for four slots, rejected by the three-slot copy
    pulse_start(2'd3, 1'b1);
    chk("s3.err", err, 0);
    chk("s3.busy", busy, 1);
    chk("s3.slot", cur_slot, 3);
    chk("bad.err", b_err, 1);
    chk("bad.busy", b_busy, 0);
    chk("bad.slot", b_cur_slot, 2);
    chk("bad.addr", b_mem_addr, 24);
    tick();
    chk("bad.err_clr", b_err, 0);
    pulse_stop();

    // Reset in the middle of a record
    pulse_start(2'd0, 1'b1);
    for (int i = 1; i <= 6; i++) samp("rrec", (i % 3) == 0, 1'b0, 16 + i / 3 - 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr.busy", busy, 0);
    chk("rr.done", done, 0);
    chk("rr.addr", mem_addr, 16);
    chk("rr.len0", slot_len, 0);
    chk("rr.slot", cur_slot, 0);
    tick();
    chk("rr.done2", done, 0);
    pulse_start(2'd1, 1'b0);
    chk("rr.len1_busy", busy, 0);
    chk("rr.len1_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/song_addr_sequencer.md
SONG_ADDR_SEQUENCER -- requirements
Module: song_addr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 19, memory address width.
REQ-002 SHALL have parameter NUM_SLOTS, 12, number of song slots.
REQ-003 SHALL have parameter SLOT_W, 4, slot index width; NUM_SLOTS <= 2**SLOT_W.
REQ-004 SHALL have parameter SLOT_LEN, 40000, words per slot; BASE_ADDR+NUM_SLOTS*SLOT_LEN <= 2**ADDR_W.
REQ-005 SHALL have parameter BASE_ADDR, 0, address of slot 0.
REQ-006 SHALL have parameter SAMPLES_PER_WORD, 3, sample_en strobes per memory word (>=1).
REQ-007 SHALL have ports clk in 1 system clock; reset in 1 synchronous, active-high.
REQ-008 SHALL have ports sample_en in 1 one-cycle strobe per audio sample; start in 1 begin take; stop in 1 end take; pause in 1 level, freeze; record in 1 1=record, 0=play (sampled at start); loop in 1 playback repeat (level).
REQ-009 SHALL have port slot in SLOT_W, slot selected at start.
REQ-010 SHALL have outputs mem_addr ADDR_W current word; mem_we 1; mem_re 1; busy 1; done 1 one-cycle pulse; err 1 one-cycle pulse; cur_slot SLOT_W; slot_len ADDR_W words stored in cur_slot.

Function
REQ-011 SHALL use states IDLE, REC, PLAY; busy=1 in REC/PLAY; everything on posedge clk.
REQ-012 SHALL keep per-slot length table len[NUM_SLOTS] (words); base(s)=BASE_ADDR+s*SLOT_LEN; offset=mem_addr-base(cur_slot).
REQ-013 Priority: reset > start > stop > pause > sample_en.
REQ-014 start, slot<NUM_SLOTS, any state: cur_slot<=slot, mem_addr<=base(slot), phase<=0; record=1 -> len[slot]<=0, REC; record=0 and len[slot]!=0 -> PLAY; record=0 and len[slot]==0 -> stay/go IDLE, done pulse next cycle.
REQ-015 start with slot>=NUM_SLOTS: ignored (state, addr, table unchanged), err pulse next cycle.
REQ-016 stop in REC/PLAY: IDLE, done pulse next cycle, len retained; stop in IDLE: no effect.
REQ-017 pause=1: phase, mem_addr, state frozen; sample_en ignored; no mem_we/mem_re.
REQ-018 Advance event adv = busy & sample_en & ~pause & ~start & ~stop; phase counts 0..SAMPLES_PER_WORD-1, wraps; word event wev = adv & phase==SAMPLES_PER_WORD-1.
REQ-019 mem_we = (state==REC)&wev, combinational, same cycle, addressing current mem_addr; mem_re likewise for PLAY.
REQ-020 REC on wev: len[cur_slot]<=offset+1; offset+1==SLOT_LEN -> IDLE, done pulse, mem_addr held; else mem_addr+1.
REQ-021 PLAY on wev: offset+1==len[cur_slot] -> loop=1: mem_addr<=base, stay PLAY, no done; loop=0: IDLE, done pulse, mem_addr held; else mem_addr+1.
REQ-022 slot_len = len[cur_slot], reflects table update the cycle after it.
REQ-023 All address arithmetic ADDR_W unsigned; never exceeds base+SLOT_LEN-1.

Reset
REQ-024 reset SHALL give: IDLE, all len=0, mem_addr=BASE_ADDR, phase=0, cur_slot=0, busy/done/err/mem_we/mem_re=0.
REQ-025 reset mid-REC/PLAY SHALL abort with no done pulse and clear all lengths.

Verification (NUM_SLOTS=4, SLOT_W=2, SLOT_LEN=4, SAMPLES_PER_WORD=3, BASE_ADDR=16)
REQ-026 Record slot 1, 12 sample_en -> mem_we on samples 3,6,9,12 at addr 20,21,22,23; done after 12th; len[1]=4; IDLE.
REQ-027 Record slot 1, stop after 6 samples, then play -> mem_re at 20,21 on samples 3,6; done after 6th; slot_len=2.
REQ-028 Same slot, loop=1 -> mem_re addr 20,21,20,21,...; no done until stop; stop -> done pulse, IDLE.
REQ-029 pause held across 5 sample_en mid-record -> no mem_we, mem_addr/phase unchanged; resumes at same phase.
REQ-030 Play empty slot 2 -> done next cycle, no mem_re; start slot=3 ok, slot beyond NUM_SLOTS (parameterise NUM_SLOTS=3, slot=3) -> err pulse, state unchanged.
REQ-031 reset during record of slot 0 after 2 words -> IDLE, len[0]=0, no done pulse, mem_addr=16.
